// File: rtl/if_pkg.sv
// ---------------------------------------------------------------------------
// if_pkg
// Shared definitions for the instruction-fetch sequencer slice.
//   state_t    : sequencer states (IDLE / LOAD / RUN)
//   PC_RESET   : PC value after reset and on every IDLE->RUN transition
//   PC_STEP    : byte increment between sequential fetches
//   word_align : clears the byte-offset bits of a byte address
// ---------------------------------------------------------------------------
package if_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    localparam logic [31:0] PC_RESET = 32'd0;
    localparam logic [31:0] PC_STEP  = 32'd4;

    // Instructions are word aligned, so branch targets drop their low two bits.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/if_next_pc_sel.sv
// ---------------------------------------------------------------------------
// if_next_pc_sel
// Combinational next-PC priority mux used while the sequencer is in RUN.
// Priority: halt (hold) > br_taken (jump + flush) > hazard_stall (hold) > PC+4.
// Ports:
//   pc           in  32  current fetch byte address
//   halt         in  1   leave RUN; PC is held
//   br_taken     in  1   branch resolved taken this cycle
//   hazard_stall in  1   hold the PC
//   br_addr      in  32  branch target byte address
//   next_pc      out 32  PC to register at the next clock edge
//   flush_set    out 1   a taken branch starts a new flush window
// ---------------------------------------------------------------------------
module if_next_pc_sel
    import if_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        halt,
    input  logic        br_taken,
    input  logic        hazard_stall,
    input  logic [31:0] br_addr,
    output logic [31:0] next_pc,
    output logic        flush_set
);

    // A branch beats a stall: the stalled instruction is on the wrong path
    // anyway, so the redirect proceeds and the flush clears it.
    always_comb begin
        next_pc   = pc;
        flush_set = 1'b0;
        if (halt) begin
            next_pc = pc;
        end else if (br_taken) begin
            next_pc   = word_align(br_addr);
            flush_set = 1'b1;
        end else if (hazard_stall) begin
            next_pc = pc;
        end else begin
            next_pc = pc + PC_STEP;
        end
    end

endmodule

// File: rtl/if_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// if_fetch_sequencer
// Sequences the instruction-fetch stage: owns the PC and the instruction-RAM
// write port, arbitrates the RAM between a boot-time loader (LOAD) and normal
// fetch (RUN), and generates the IF-stage flush after a taken branch.
// Parameters:
//   ADDR_W       instruction-RAM word-address width (depth = 2**ADDR_W)
//   FLUSH_CYCLES flush pulse length after a taken branch, 1..3
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   load_start          enter LOAD (only from IDLE; wins over run_req)
//   load_valid/last/data loader word stream
//   load_ready          high in LOAD
//   run_req, halt       IDLE->RUN and RUN->IDLE requests
//   hazard_stall        hold PC and IF/ID register
//   br_taken, br_addr   taken-branch redirect from EXE
//   pc, pc_en, flush    fetch address, IF/ID enable, IF/ID clear
//   imem_we/waddr/wdata instruction-RAM write port
//   busy_load, running  state indicators
// ---------------------------------------------------------------------------
module if_fetch_sequencer
    import if_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic              load_last,
    input  logic [31:0]       load_data,
    output logic              load_ready,
    input  logic              run_req,
    input  logic              halt,
    input  logic              hazard_stall,
    input  logic              br_taken,
    input  logic [31:0]       br_addr,
    output logic [31:0]       pc,
    output logic              pc_en,
    output logic              flush,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              busy_load,
    output logic              running
);

    localparam logic [ADDR_W-1:0] CNT_MAX    = '1;
    localparam logic [1:0]        FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

    state_t            state;
    logic [ADDR_W-1:0] load_cnt;
    logic [1:0]        flush_cnt;

    logic              in_load;
    logic              in_run;
    logic              accept;
    logic              flush_pending;
    logic [31:0]       next_pc;
    logic              flush_set;

    if_next_pc_sel u_next_pc_sel (
        .pc           (pc),
        .halt         (halt),
        .br_taken     (br_taken),
        .hazard_stall (hazard_stall),
        .br_addr      (br_addr),
        .next_pc      (next_pc),
        .flush_set    (flush_set)
    );

    // State decodes and the same-cycle strobes. The write strobe and flush
    // must respond in the deciding cycle, so they combine registered state
    // with the current inputs.
    always_comb begin
        in_load       = (state == S_LOAD);
        in_run        = (state == S_RUN);
        accept        = in_load & load_valid;
        flush_pending = (flush_cnt != 2'd0);

        load_ready = in_load;
        busy_load  = in_load;
        running    = in_run;

        imem_we    = accept;
        imem_waddr = in_load ? load_cnt : '0;
        imem_wdata = load_data;

        flush = in_run & (flush_set | flush_pending);
        pc_en = in_run & (~hazard_stall | flush);
    end

    // Sequencer FSM with the PC, load counter and flush counter.
    // The load counter saturates at the last RAM word so a runaway loader can
    // never wrap around and overwrite word 0; reaching it also ends the load.
    // Leaving RUN or re-entering it drops any pending flush cycles so a stale
    // window cannot leak into the next run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            pc        <= PC_RESET;
            load_cnt  <= '0;
            flush_cnt <= 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load_start) begin
                        state    <= S_LOAD;
                        load_cnt <= '0;
                    end else if (run_req) begin
                        state     <= S_RUN;
                        pc        <= PC_RESET;
                        flush_cnt <= 2'd0;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if (load_last || (load_cnt == CNT_MAX)) begin
                            state <= S_IDLE;
                        end
                        if (load_cnt != CNT_MAX) begin
                            load_cnt <= load_cnt + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    pc <= next_pc;
                    if (halt) begin
                        state     <= S_IDLE;
                        flush_cnt <= 2'd0;
                    end else if (flush_set) begin
                        flush_cnt <= FLUSH_INIT;
                    end else if (flush_pending) begin
                        flush_cnt <= flush_cnt - 2'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_sequencer
// Self-checking bench for if_fetch_sequencer. Two instances share all inputs:
// one with a 1-cycle flush and one with a 3-cycle flush. A behavioural model
// (mode, PC, next write index, remaining flush cycles) predicts every output.
// ---------------------------------------------------------------------------
module tb_if_fetch_sequencer;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_RUN  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        load_start;
    logic        load_valid;
    logic        load_last;
    logic [31:0] load_data;
    logic        run_req;
    logic        halt;
    logic        hazard_stall;
    logic        br_taken;
    logic [31:0] br_addr;

    logic              load_ready_1, load_ready_3;
    logic [31:0]       pc_1, pc_3;
    logic              pc_en_1, pc_en_3;
    logic              flush_1, flush_3;
    logic              imem_we_1, imem_we_3;
    logic [ADDR_W-1:0] imem_waddr_1, imem_waddr_3;
    logic [31:0]       imem_wdata_1, imem_wdata_3;
    logic              busy_load_1, busy_load_3;
    logic              running_1, running_3;

    if_fetch_sequencer #(.ADDR_W(ADDR_W), .FLUSH_CYCLES(1)) dut_1 (
        .clk(clk), .rst(rst),
        .load_start(load_start), .load_valid(load_valid), .load_last(load_last),
        .load_data(load_data), .load_ready(load_ready_1),
        .run_req(run_req), .halt(halt), .hazard_stall(hazard_stall),
        .br_taken(br_taken), .br_addr(br_addr),
        .pc(pc_1), .pc_en(pc_en_1), .flush(flush_1),
        .imem_we(imem_we_1), .imem_waddr(imem_waddr_1), .imem_wdata(imem_wdata_1),
        .busy_load(busy_load_1), .running(running_1)
    );

    if_fetch_sequencer #(.ADDR_W(ADDR_W), .FLUSH_CYCLES(3)) dut_3 (
        .clk(clk), .rst(rst),
        .load_start(load_start), .load_valid(load_valid), .load_last(load_last),
        .load_data(load_data), .load_ready(load_ready_3),
        .run_req(run_req), .halt(halt), .hazard_stall(hazard_stall),
        .br_taken(br_taken), .br_addr(br_addr),
        .pc(pc_3), .pc_en(pc_en_3), .flush(flush_3),
        .imem_we(imem_we_3), .imem_waddr(imem_waddr_3), .imem_wdata(imem_wdata_3),
        .busy_load(busy_load_3), .running(running_3)
    );

    // Reference model state
    int          mode;
    logic [31:0] m_pc;
    int          m_widx;
    int          m_rem1;
    int          m_rem3;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    logic [31:0] words [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mode   = M_IDLE;
        m_pc   = 32'd0;
        m_widx = 0;
        m_rem1 = 0;
        m_rem3 = 0;
    endtask

    // Outputs that depend on the current inputs, checked before the edge.
    task automatic check_comb();
        logic in_run;
        logic br_eff;
        logic exp_fl1;
        logic exp_fl3;
        in_run  = (mode == M_RUN);
        br_eff  = br_taken & ~halt;
        exp_fl1 = in_run && (br_eff || m_rem1 > 0);
        exp_fl3 = in_run && (br_eff || m_rem3 > 0);
        chk("load_ready_1", 32'(load_ready_1), 32'(mode == M_LOAD));
        chk("load_ready_3", 32'(load_ready_3), 32'(mode == M_LOAD));
        chk("imem_we_1", 32'(imem_we_1), 32'((mode == M_LOAD) && load_valid));
        chk("imem_we_3", 32'(imem_we_3), 32'((mode == M_LOAD) && load_valid));
        chk("imem_waddr", 32'(imem_waddr_1), (mode == M_LOAD) ? 32'(m_widx) : 32'd0);
        chk("imem_wdata", imem_wdata_1, load_data);
        chk("flush_1", 32'(flush_1), 32'(exp_fl1));
        chk("flush_3", 32'(flush_3), 32'(exp_fl3));
        chk("pc_en_1", 32'(pc_en_1), 32'(in_run && (!hazard_stall || exp_fl1)));
        chk("pc_en_3", 32'(pc_en_3), 32'(in_run && (!hazard_stall || exp_fl3)));
    endtask

    // Registered state, checked after the edge.
    task automatic check_state();
        chk("pc_1", pc_1, m_pc);
        chk("pc_3", pc_3, m_pc);
        chk("busy_load", 32'(busy_load_1), 32'(mode == M_LOAD));
        chk("running_1", 32'(running_1), 32'(mode == M_RUN));
        chk("running_3", 32'(running_3), 32'(mode == M_RUN));
    endtask

    // One clock of the specification's behaviour.
    task automatic model_edge();
        case (mode)
            M_IDLE: begin
                if (load_start) begin
                    mode   = M_LOAD;
                    m_widx = 0;
                end else if (run_req) begin
                    mode   = M_RUN;
                    m_pc   = 32'd0;
                    m_rem1 = 0;
                    m_rem3 = 0;
                end
            end
            M_LOAD: begin
                if (load_valid) begin
                    if (load_last || m_widx == DEPTH - 1) mode = M_IDLE;
                    if (m_widx < DEPTH - 1) m_widx++;
                end
            end
            default: begin
                if (halt) begin
                    mode   = M_IDLE;
                    m_rem1 = 0;
                    m_rem3 = 0;
                end else if (br_taken) begin
                    m_pc   = br_addr & ~32'd3;
                    m_rem1 = 0;
                    m_rem3 = 2;
                end else begin
                    if (!hazard_stall) m_pc = m_pc + 32'd4;
                    if (m_rem1 > 0) m_rem1--;
                    if (m_rem3 > 0) m_rem3--;
                end
            end
        endcase
    endtask

    task automatic applyStimulus();
        #1;
        check_comb();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_state();
    endtask

    task automatic idle_inputs();
        load_start   = 1'b0;
        load_valid   = 1'b0;
        load_last    = 1'b0;
        run_req      = 1'b0;
        halt         = 1'b0;
        hazard_stall = 1'b0;
        br_taken     = 1'b0;
        br_addr      = 32'd0;
        load_data    = 32'd0;
    endtask

    initial begin
        words[0] = 32'hA;
        words[1] = 32'hB;
        words[2] = 32'hC;

        // Reset state
        rst = 1'b0;
        idle_inputs();
        model_reset();
        #12;
        check_comb();
        check_state();
        @(negedge clk);
        rst = 1'b1;

        // Three-word load ending on load_last
        load_start = 1'b1;
        applyStimulus();
        load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_data  = words[i];
            load_last  = (i == 2);
            applyStimulus();
        end
        idle_inputs();
        applyStimulus();

        // Free-running fetch
        run_req = 1'b1;
        applyStimulus();
        run_req = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus();

        // Branch at pc=0x10 to 0x23 -> 0x20, then watch the flush windows
        br_taken = 1'b1;
        br_addr  = 32'h23;
        applyStimulus();
        br_taken = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus();

        // Halt, restart, stall at pc=0x8, then branch during the stall
        halt = 1'b1;
        applyStimulus();
        halt    = 1'b0;
        run_req = 1'b1;
        applyStimulus();
        run_req = 1'b0;
        applyStimulus();
        applyStimulus();
        hazard_stall = 1'b1;
        applyStimulus();
        applyStimulus();
        br_taken = 1'b1;
        br_addr  = 32'h40;
        applyStimulus();
        br_taken = 1'b0;
        applyStimulus();

        // Asynchronous reset mid-RUN at pc=0x40
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_comb();
        check_state();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();

        // load_start and run_req together: LOAD wins
        load_start = 1'b1;
        run_req    = 1'b1;
        applyStimulus();
        idle_inputs();
        load_valid = 1'b1;
        load_last  = 1'b1;
        load_data  = 32'h1234_5678;
        applyStimulus();
        idle_inputs();
        applyStimulus();

        // Full-depth load without load_last; branches and run requests ignored
        load_start = 1'b1;
        applyStimulus();
        load_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 5) begin
                load_valid = 1'b0;
                applyStimulus();
            end
            load_valid = 1'b1;
            load_last  = 1'b0;
            load_data  = $urandom;
            br_taken   = 1'($urandom_range(0, 1));
            run_req    = 1'($urandom_range(0, 1));
            br_addr    = $urandom;
            applyStimulus();
        end
        idle_inputs();
        applyStimulus();

        // PC wrap at the top of the address space
        run_req = 1'b1;
        applyStimulus();
        run_req  = 1'b0;
        br_taken = 1'b1;
        br_addr  = 32'hFFFF_FFFF;
        applyStimulus();
        br_taken = 1'b0;
        applyStimulus();

        // Randomized RUN traffic
        for (int i = 0; i < 400; i++) begin
            idle_inputs();
            if (mode == M_IDLE) begin
                run_req = 1'b1;
            end else begin
                hazard_stall = ($urandom_range(0, 3) == 0);
                br_taken     = ($urandom_range(0, 4) == 0);
                br_addr      = $urandom;
                run_req      = 1'($urandom_range(0, 1));
                if (!br_taken && m_rem1 == 0 && m_rem3 == 0 && $urandom_range(0, 39) == 0)
                    halt = 1'b1;
            end
            applyStimulus();
        end
        idle_inputs();
        applyStimulus();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
